// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
// Hazard and forwarding controller for the 5-stage RISC-V core. It keeps a
// shadow copy of the register-file control fields of the E, M and W stages.
// From these it drives:
//   - the Execute-stage operand forwarding selects
//   - load-use stalls, branch flushes and data-memory wait stalls
//   - a saturating stall-cycle counter for performance monitoring
//
// Ports
//   clk, reset_n            core clock (rising edge), async active-low reset
//   Rs1D, Rs2D, RdD         Decode-stage source/destination registers
//   RegWriteD, LoadD        Decode instruction writes RdD / is a load
//   PCSrcE                  taken branch/jump resolved in Execute
//   DMemReadyM              data memory ready (0 = wait)
//   ForwardAE, ForwardBE    00 = regfile, 01 = W result, 10 = M ALU result
//   StallF, StallD          front-end hold (load-use or memory wait)
//   FlushD, FlushE          front-end flush (branch, load-use bubble)
//   StallE, StallM, StallW  back-end hold (memory wait)
//   StallCnt                saturating count of cycles with StallF = 1
module hazard_fwd_unit #(
  parameter int REGW = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [REGW-1:0] Rs1D,
  input  logic [REGW-1:0] Rs2D,
  input  logic [REGW-1:0] RdD,
  input  logic            RegWriteD,
  input  logic            LoadD,
  input  logic            PCSrcE,
  input  logic            DMemReadyM,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic            FlushE,
  output logic            StallE,
  output logic            StallM,
  output logic            StallW,
  output logic [CNTW-1:0] StallCnt
);

  localparam logic [REGW-1:0] X0      = '0;
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [REGW-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic            reg_write_e, load_e, reg_write_m, reg_write_w;
  logic            mem_stall, lw_stall;

  assign mem_stall = !DMemReadyM;

  // A taken branch kills the dependent D instruction anyway, so it never
  // needs to wait for the load.
  assign lw_stall = load_e && (rd_e != X0) &&
                    ((rd_e == Rs1D) || (rd_e == Rs2D)) && !PCSrcE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rs1_e       <= '0;
      rs2_e       <= '0;
      rd_e        <= '0;
      reg_write_e <= 1'b0;
      load_e      <= 1'b0;
      rd_m        <= '0;
      reg_write_m <= 1'b0;
      rd_w        <= '0;
      reg_write_w <= 1'b0;
    end else if (!mem_stall) begin
      // Memory wait freezes everything; a held PCSrcE flushes once ready.
      rd_m        <= rd_e;
      reg_write_m <= reg_write_e;
      rd_w        <= rd_m;
      reg_write_w <= reg_write_m;
      if (PCSrcE || lw_stall) begin
        rs1_e       <= '0;
        rs2_e       <= '0;
        rd_e        <= '0;
        reg_write_e <= 1'b0;
        load_e      <= 1'b0;
      end else begin
        rs1_e       <= Rs1D;
        rs2_e       <= Rs2D;
        rd_e        <= RdD;
        reg_write_e <= RegWriteD;
        load_e      <= LoadD;
      end
    end
  end

  // M has priority over W: it holds the younger write to the same register.
  function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] rs);
    if (reg_write_m && (rd_m == rs) && (rs != X0))      fwd_sel = 2'b10;
    else if (reg_write_w && (rd_w == rs) && (rs != X0)) fwd_sel = 2'b01;
    else                                                fwd_sel = 2'b00;
  endfunction

  always_comb begin
    ForwardAE = fwd_sel(rs1_e);
    ForwardBE = fwd_sel(rs2_e);
  end

  assign StallF = lw_stall || mem_stall;
  assign StallD = lw_stall || mem_stall;
  assign StallE = mem_stall;
  assign StallM = mem_stall;
  assign StallW = mem_stall;
  assign FlushD = PCSrcE && !mem_stall;
  assign FlushE = (PCSrcE || lw_stall) && !mem_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      StallCnt <= '0;
    else if (StallF && (StallCnt != CNT_MAX))
      StallCnt <= StallCnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;

  localparam int REGW = 5;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [REGW-1:0] Rs1D, Rs2D, RdD;
  logic            RegWriteD, LoadD, PCSrcE, DMemReadyM;
  logic [1:0]      ForwardAE, ForwardBE;
  logic            StallF, StallD, FlushD, FlushE, StallE, StallM, StallW;
  logic [CNTW-1:0] StallCnt;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_fwd_unit #(.REGW(REGW), .CNTW(CNTW)) dut (
    .clk(clk), .reset_n(reset_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .LoadD(LoadD), .PCSrcE(PCSrcE), .DMemReadyM(DMemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .StallE(StallE), .StallM(StallM), .StallW(StallW), .StallCnt(StallCnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic       rw, ld, pc, rdy;
    logic [1:0] fa, fb;
    logic       sf, sb, fd, fe;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int rs1, int rs2, int rd, bit rw, bit ld, bit pc, bit rdy,
                              int fa, int fb, bit sf, bit sb, bit fd, bit fe, int cnt);
    vec_t v;
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
    v.rw = rw; v.ld = ld; v.pc = pc; v.rdy = rdy;
    v.fa = 2'(fa); v.fb = 2'(fb);
    v.sf = sf; v.sb = sb; v.fd = fd; v.fe = fe; v.cnt = 4'(cnt);
    return v;
  endfunction

  // Packed view of all outputs: {fa,fb,StallF,StallD,StallE,StallM,StallW,FlushD,FlushE,cnt}
  function automatic logic [16:0] outs();
    return {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW,
            FlushD, FlushE, StallCnt};
  endfunction

  function automatic logic [16:0] exp_of(vec_t v);
    return {v.fa, v.fb, v.sf, v.sf, v.sb, v.sb, v.sb, v.fd, v.fe, v.cnt};
  endfunction

  task automatic check(string name, logic [16:0] act, logic [16:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (fa,fb,sF,sD,sE,sM,sW,fD,fE,cnt)",
               name, act, exp);
    end
  endtask

  task automatic drive(int rs1, int rs2, int rd, bit rw, bit ld, bit pc, bit rdy);
    Rs1D = 5'(rs1); Rs2D = 5'(rs2); RdD = 5'(rd);
    RegWriteD = rw; LoadD = ld; PCSrcE = pc; DMemReadyM = rdy;
  endtask

  initial begin
    //             rs1 rs2 rd rw ld pc rdy  fa  fb sf sb fd fe cnt
    vecs.push_back(mk( 0, 0, 5, 1, 0, 0, 1,  0,  0, 0, 0, 0, 0, 0)); // 0 add x5
    vecs.push_back(mk( 5, 5, 6, 1, 0, 0, 1,  0,  0, 0, 0, 0, 0, 0)); // 1 uses x5
    vecs.push_back(mk( 0, 5, 8, 1, 0, 0, 1,  2,  2, 0, 0, 0, 0, 0)); // 2 E sees M fwd
    vecs.push_back(mk( 0, 0, 0, 0, 0, 0, 1,  0,  1, 0, 0, 0, 0, 0)); // 3 rs2=5 from W
    vecs.push_back(mk( 1, 0, 7, 1, 1, 0, 1,  0,  0, 0, 0, 0, 0, 0)); // 4 lw x7
    vecs.push_back(mk( 7, 2, 9, 1, 0, 0, 1,  0,  0, 1, 0, 0, 1, 0)); // 5 load-use stall
    vecs.push_back(mk( 7, 2, 9, 1, 0, 0, 1,  0,  0, 0, 0, 0, 0, 1)); // 6 re-presented
    vecs.push_back(mk( 0, 0, 0, 0, 0, 0, 1,  1,  0, 0, 0, 0, 0, 1)); // 7 dependent in E: W fwd
    vecs.push_back(mk( 0, 0, 0, 1, 0, 0, 1,  0,  0, 0, 0, 0, 0, 1)); // 8 write x0
    vecs.push_back(mk( 0, 0, 0, 0, 0, 0, 1,  0,  0, 0, 0, 0, 0, 1)); // 9
    vecs.push_back(mk( 0, 0, 0, 0, 0, 0, 1,  0,  0, 0, 0, 0, 0, 1)); // 10 x0 in M not fwd
    vecs.push_back(mk( 0, 0, 3, 1, 0, 0, 1,  0,  0, 0, 0, 0, 0, 1)); // 11 write x3
    vecs.push_back(mk( 0, 0, 3, 1, 0, 0, 1,  0,  0, 0, 0, 0, 0, 1)); // 12 write x3 again
    vecs.push_back(mk( 3, 4, 0, 0, 0, 0, 1,  0,  0, 0, 0, 0, 0, 1)); // 13 reads x3
    vecs.push_back(mk( 0, 0, 0, 0, 0, 0, 1,  2,  0, 0, 0, 0, 0, 1)); // 14 M beats W
    vecs.push_back(mk( 0, 0, 0, 1, 1, 0, 1,  0,  0, 0, 0, 0, 0, 1)); // 15 lw x0
    vecs.push_back(mk( 0, 0, 0, 0, 0, 0, 1,  0,  0, 0, 0, 0, 0, 1)); // 16 no x0 stall
    vecs.push_back(mk( 0, 0,10, 1, 1, 0, 1,  0,  0, 0, 0, 0, 0, 1)); // 17 lw x10
    vecs.push_back(mk(10, 0, 0, 0, 0, 1, 1,  0,  0, 0, 0, 1, 1, 1)); // 18 branch beats lw
    vecs.push_back(mk( 0, 0, 0, 0, 0, 0, 1,  0,  0, 0, 0, 0, 0, 1)); // 19 cnt unchanged
    vecs.push_back(mk( 0, 0,11, 1, 0, 0, 1,  0,  0, 0, 0, 0, 0, 1)); // 20 write x11
    vecs.push_back(mk(11, 0, 0, 0, 0, 0, 1,  0,  0, 0, 0, 0, 0, 1)); // 21 reads x11
    vecs.push_back(mk( 0, 0, 0, 0, 0, 1, 0,  2,  0, 1, 1, 0, 0, 1)); // 22 mem wait + branch
    vecs.push_back(mk( 0, 0, 0, 0, 0, 1, 0,  2,  0, 1, 1, 0, 0, 2)); // 23 frozen
    vecs.push_back(mk( 0, 0, 0, 0, 0, 1, 0,  2,  0, 1, 1, 0, 0, 3)); // 24 frozen
    vecs.push_back(mk( 0, 0, 0, 0, 0, 1, 1,  2,  0, 0, 0, 1, 1, 4)); // 25 deferred flush
    vecs.push_back(mk( 0, 0, 0, 0, 0, 0, 1,  0,  0, 0, 0, 0, 0, 4)); // 26 bubble in E
    vecs.push_back(mk( 0, 0,12, 1, 1, 0, 1,  0,  0, 0, 0, 0, 0, 4)); // 27 lw x12
    vecs.push_back(mk( 0,12, 0, 0, 0, 0, 1,  0,  0, 1, 0, 0, 1, 4)); // 28 rs2 load-use
    vecs.push_back(mk( 0,12, 0, 0, 0, 0, 1,  0,  0, 0, 0, 0, 0, 5)); // 29 re-presented
    vecs.push_back(mk( 0, 0, 0, 0, 0, 0, 1,  0,  1, 0, 0, 0, 0, 5)); // 30 rs2 from W

    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);
    #12;
    check("reset_outputs", outs(), 17'd0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].rw, vecs[i].ld,
            vecs[i].pc, vecs[i].rdy);
      #3;
      check($sformatf("vec%0d", i), outs(), exp_of(vecs[i]));
    end

    // Long memory wait: counter saturates at 15 from 5.
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (20) @(posedge clk);
    #1;
    check("saturate", outs(), {2'b00, 7'b1111100, 4'd15});

    // Reset mid-wait: counter clears at once, mem-driven stalls stay live.
    reset_n = 1'b0;
    #2;
    check("reset_mid_wait", outs(), {2'b00, 7'b1111100, 4'd0});
    DMemReadyM = 1'b1;
    #1;
    check("reset_ready", outs(), 17'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("after_reset", outs(), 17'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
